lsu_writeback: RTL and testbench

- Load/store execution stage between register-file read ports and register-file write port.
- Consumes rs1 (base) and rs2 (store data) from the RegisterFile.
- Runs one data-memory transaction over a req/gnt/rvalid handshake.
- For loads, produces the write-back triple (rf_en, rf_rd, rf_data) that drives the RegisterFile en/readRd/data_in inputs.

---
 rtl/lsu_writeback.sv | 264 ++++++++++++++++++++++++++
 tb/tb_lsu_writeback.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : lsu_writeback
// Purpose  : Load/store execution stage. It takes rs1 (base) and rs2 (store
//            data) from the register file and runs one data-memory transaction
//            over a req/gnt/rvalid handshake. For loads it produces the
//            register-file write-back triple (rf_en, rf_rd, rf_data).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN       datapath / address width (the RV32 byte-lane logic assumes 32)
//   RF_ADDR_W  register index width
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   start                 one-cycle access request, sampled only in IDLE
//   is_store, funct3      access type and RV32I width/sign code
//   base, offset          rs1 value and signed 12-bit immediate
//   store_data, rd_in     rs2 value and load destination index
//   busy, done, misalign  status; done is a one-cycle pulse
//   mem_*                 data-memory request channel and read response
//   rf_en, rf_rd, rf_data register-file write port
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses skip
//                         memory and complete with misalign = 1. When not
//                         defined, the low address bits are forced to the
//                         natural lane and the access proceeds normally.
// ============================================================================
module lsu_writeback #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      base,
  input  logic [11:0]          offset,
  input  logic [XLEN-1:0]      store_data,
  input  logic [RF_ADDR_W-1:0] rd_in,
  output logic                 busy,
  output logic                 done,
  output logic                 misalign,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 rf_en,
  output logic [RF_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]      rf_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] C_SIZE_B = 2'b00;
  localparam logic [1:0] C_SIZE_H = 2'b01;

  state_t state, state_nxt;

  // Request decode, evaluated from the live inputs in the start cycle
  logic [XLEN-1:0] w_ea;
  logic [1:0]      w_size;
  logic            w_legal;
  logic            w_misalign;
  logic            w_skip;
  logic [1:0]      w_lane;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;

  // Latched transaction
  logic                 r_is_store;
  logic [2:0]           r_funct3;
  logic [1:0]           r_lane;
  logic [RF_ADDR_W-1:0] r_rd;
  logic                 r_skip;
  logic                 r_we;
  logic [XLEN-1:0]      r_addr;
  logic [XLEN-1:0]      r_wdata;
  logic [3:0]           r_be;
  logic [RF_ADDR_W-1:0] r_rf_rd;
  logic [XLEN-1:0]      r_rf_data;

  // Load extraction
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_data;

  assign w_ea   = base + {{(XLEN-12){offset[11]}}, offset};
  assign w_size = funct3[1:0];

  // Loads accept B/H/W/BU/HU; stores accept only SB/SH/SW.
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~is_store;
      default:                w_legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = w_legal &
                      (((w_size == C_SIZE_H) & w_ea[0]) |
                       ((w_size == 2'b10) & (w_ea[1:0] != 2'b00)));
  assign w_lane     = w_ea[1:0];
`else
  // Without trapping, misaligned low bits are snapped to the natural lane.
  assign w_misalign = 1'b0;
  always_comb begin
    w_lane = 2'b00;
    case (w_size)
      C_SIZE_B: w_lane = w_ea[1:0];
      C_SIZE_H: w_lane = {w_ea[1], 1'b0};
      default:  w_lane = 2'b00;
    endcase
  end
`endif

  assign w_skip = ~w_legal | w_misalign;

  // Byte enables follow the access lane for loads and stores alike; stores
  // replicate the data across every lane so the memory just applies mem_be.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (w_size)
      C_SIZE_B: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {(XLEN/8){store_data[7:0]}};
      end
      C_SIZE_H: begin
        w_be    = 4'b0011 << w_lane;
        w_wdata = {(XLEN/16){store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_req   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = w_skip ? S_DONE : S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = r_is_store ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the request; nothing here changes until the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_lane     <= 2'b00;
      r_rd       <= '0;
      r_skip     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= 4'b0000;
    end else if ((state == S_IDLE) && start) begin
      r_is_store <= is_store;
      r_funct3   <= funct3;
      r_lane     <= w_lane;
      r_rd       <= rd_in;
      r_skip     <= w_skip;
      r_we       <= is_store & ~w_skip;
      r_addr     <= {w_ea[XLEN-1:2], 2'b00};
      r_wdata    <= w_wdata;
      r_be       <= w_be;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_misalign <= 1'b0;
    else if ((state == S_IDLE) && start) r_misalign <= w_misalign;
  end
  assign misalign = done & r_misalign;
`else
  assign misalign = 1'b0;
`endif

  // Load data extraction from the returned word
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
  end

  assign w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load_data = mem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  // Write-back registers only move for a load that will actually write, so
  // rf_rd/rf_data keep their previous contents across rd = 0 loads and stores.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_rd   <= '0;
      r_rf_data <= '0;
    end else if ((state == S_WAIT) && mem_rvalid && (r_rd != '0)) begin
      r_rf_rd   <= r_rd;
      r_rf_data <= w_load_data;
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;
  assign rf_en     = done & ~r_is_store & ~r_skip & (r_rd != '0);
  assign rf_rd     = r_rf_rd;
  assign rf_data   = r_rf_data;

endmodule
`default_nettype wire

// File: tb/tb_lsu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_writeback
// Purpose  : Directed, table-driven self-checking bench for lsu_writeback,
//            plus hand-written reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_writeback;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [11:0] offset;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  lsu_writeback #(.XLEN(32), .RF_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .funct3(funct3), .base(base), .offset(offset), .store_data(store_data),
    .rd_in(rd_in), .busy(busy), .done(done), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_en(rf_en),
    .rf_rd(rf_rd), .rf_data(rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [11:0] off;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          dly;
    logic        poke;
    logic        skip;
    logic        mis;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rfen;
    logic [31:0] rfdata;
    int          lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  int tests = 0;
  int failures = 0;
  logic [4:0]  last_rd   = 5'd0;
  logic [31:0] last_data = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic st, input logic [2:0] f3,
                              input logic [31:0] b, input logic [11:0] o,
                              input logic [31:0] sd, input logic [4:0] rd,
                              input logic [31:0] rdat, input int dly, input logic poke,
                              input logic skip, input logic mis, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic rfen, input logic [31:0] rfd, input int lat);
    vec_t v;
    v.name = nm; v.st = st; v.f3 = f3; v.base = b; v.off = o; v.sdata = sd;
    v.rd = rd; v.rdata = rdat; v.dly = dly; v.poke = poke; v.skip = skip;
    v.mis = mis; v.addr = addr; v.be = be; v.wdata = wd; v.rfen = rfen;
    v.rfdata = rfd; v.lat = lat;
    return v;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; is_store = 1'b0; funct3 = 3'b000; base = 32'd0;
    offset = 12'd0; store_data = 32'd0; rd_in = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
  endtask

  // One access: start at cycle 0, zero-wait memory unless t.dly > 0.
  task automatic run_vec(input vec_t t);
    int cyc = 0;
    int req_cycles = 0;
    bit gnt_given = 0;
    bit rvalid_next = 0;
    bit req_seen = 0;
    bit done_seen = 0;
    @(negedge clk);
    chk({t.name, "/pre_done"}, {31'd0, done}, 32'd0);
    chk({t.name, "/pre_busy"}, {31'd0, busy}, 32'd0);
    start = 1'b1; is_store = t.st; funct3 = t.f3; base = t.base;
    offset = t.off; store_data = t.sdata; rd_in = t.rd;
    @(negedge clk);
    cyc = 1;
    // Scramble the request inputs: the DUT must work from latched values.
    start = 1'b0; is_store = ~t.st; funct3 = 3'b111; base = 32'hFFFF_FFF0;
    offset = 12'h7FF; store_data = 32'h5A5A_5A5A; rd_in = 5'd30;
    while (cyc < 40 && !done_seen) begin
      if (done) begin
        done_seen = 1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; start = 1'b0;
        if (t.rfen) begin
          last_rd = t.rd;
          last_data = t.rfdata;
        end
        chk({t.name, "/latency"}, cyc, t.lat);
        chk({t.name, "/rf_en"}, {31'd0, rf_en}, {31'd0, t.rfen});
        chk({t.name, "/rf_rd"}, {27'd0, rf_rd}, {27'd0, last_rd});
        chk({t.name, "/rf_data"}, rf_data, last_data);
        chk({t.name, "/misalign"}, {31'd0, misalign}, {31'd0, t.mis});
      end else begin
        if (mem_req) begin
          if (t.skip || gnt_given) begin
            chk({t.name, "/unexpected_req"}, {31'd0, mem_req}, 32'd0);
          end else begin
            chk({t.name, "/addr"}, mem_addr, t.addr);
            chk({t.name, "/be"}, {28'd0, mem_be}, {28'd0, t.be});
            chk({t.name, "/we"}, {31'd0, mem_we}, {31'd0, t.st});
            if (t.st) chk({t.name, "/wdata"}, mem_wdata, t.wdata);
          end
          req_seen = 1;
        end
        mem_rvalid = rvalid_next;
        mem_rdata  = rvalid_next ? t.rdata : 32'h0BAD_0BAD;
        rvalid_next = 0;
        if (mem_req && !gnt_given && req_cycles == t.dly) begin
          mem_gnt = 1'b1;
          gnt_given = 1;
          rvalid_next = !t.st;
        end else begin
          mem_gnt = 1'b0;
        end
        if (mem_req) req_cycles++;
        start = t.poke && mem_req;
        @(negedge clk);
        cyc++;
      end
    end
    if (!done_seen) chk({t.name, "/timeout_done"}, 32'd0, 32'd1);
    chk({t.name, "/req_seen"}, {31'd0, req_seen}, {31'd0, !t.skip});
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;

    vecs[0]  = mk("lw",      0, 3'b010, 32'h100, 12'h004, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0,
                  0, 0, 32'h104, 4'b1111, 32'h0, 1, 32'hDEADBEEF, 3);
    vecs[1]  = mk("lb",      0, 3'b000, 32'h200, 12'h003, 32'h0, 5'd6, 32'h80FFFFFF, 0, 0,
                  0, 0, 32'h200, 4'b1000, 32'h0, 1, 32'hFFFFFF80, 3);
    vecs[2]  = mk("lbu",     0, 3'b100, 32'h204, 12'hFFF, 32'h0, 5'd7, 32'h80FFFFFF, 0, 0,
                  0, 0, 32'h200, 4'b1000, 32'h0, 1, 32'h00000080, 3);
    vecs[3]  = mk("lh",      0, 3'b001, 32'h300, 12'h002, 32'h0, 5'd8, 32'h80011234, 0, 0,
                  0, 0, 32'h300, 4'b1100, 32'h0, 1, 32'hFFFF8001, 3);
    vecs[4]  = mk("lhu",     0, 3'b101, 32'h300, 12'h000, 32'h0, 5'd9, 32'h8001F234, 0, 0,
                  0, 0, 32'h300, 4'b0011, 32'h0, 1, 32'h0000F234, 3);
    vecs[5]  = mk("lw_rd0",  0, 3'b010, 32'h010, 12'h000, 32'h0, 5'd0, 32'h11111111, 0, 0,
                  0, 0, 32'h010, 4'b1111, 32'h0, 0, 32'h0, 3);
    vecs[6]  = mk("sh",      1, 3'b001, 32'h100, 12'h002, 32'h1234ABCD, 5'd3, 32'h0, 0, 0,
                  0, 0, 32'h100, 4'b1100, 32'hABCDABCD, 0, 32'h0, 2);
    vecs[7]  = mk("sh_gnt3", 1, 3'b001, 32'h100, 12'h002, 32'h1234ABCD, 5'd3, 32'h0, 3, 1,
                  0, 0, 32'h100, 4'b1100, 32'hABCDABCD, 0, 32'h0, 5);
    vecs[8]  = mk("sb",      1, 3'b000, 32'h400, 12'h001, 32'h000000A5, 5'd0, 32'h0, 0, 0,
                  0, 0, 32'h400, 4'b0010, 32'hA5A5A5A5, 0, 32'h0, 2);
    vecs[9]  = mk("sw",      1, 3'b010, 32'h7FC, 12'h004, 32'hCAFEF00D, 5'd0, 32'h0, 0, 0,
                  0, 0, 32'h800, 4'b1111, 32'hCAFEF00D, 0, 32'h0, 2);
    vecs[10] = mk("ill_ld",  0, 3'b011, 32'h100, 12'h000, 32'h0, 5'd4, 32'h0, 0, 0,
                  1, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
    vecs[11] = mk("ill_st",  1, 3'b011, 32'h100, 12'h000, 32'h0, 5'd4, 32'h0, 0, 0,
                  1, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
    vecs[12] = mk("lb_wrap", 0, 3'b000, 32'h001, 12'hFFE, 32'h0, 5'd31, 32'h7F000000, 0, 0,
                  0, 0, 32'hFFFFFFFC, 4'b1000, 32'h0, 1, 32'h0000007F, 3);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[13] = mk("lw_mis",  0, 3'b010, 32'h101, 12'h000, 32'h0, 5'd10, 32'h55AA55AA, 0, 0,
                  1, 1, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
    vecs[14] = mk("sh_mis",  1, 3'b001, 32'h103, 12'h000, 32'h0000BEEF, 5'd0, 32'h0, 0, 0,
                  1, 1, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
    vecs[15] = mk("lh_mis",  0, 3'b001, 32'h101, 12'h000, 32'h0, 5'd11, 32'h12348765, 0, 0,
                  1, 1, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1);
`else
    vecs[13] = mk("lw_mis",  0, 3'b010, 32'h101, 12'h000, 32'h0, 5'd10, 32'h55AA55AA, 0, 0,
                  0, 0, 32'h100, 4'b1111, 32'h0, 1, 32'h55AA55AA, 3);
    vecs[14] = mk("sh_mis",  1, 3'b001, 32'h103, 12'h000, 32'h0000BEEF, 5'd0, 32'h0, 0, 0,
                  0, 0, 32'h100, 4'b1100, 32'hBEEFBEEF, 0, 32'h0, 2);
    vecs[15] = mk("lh_mis",  0, 3'b001, 32'h101, 12'h000, 32'h0, 5'd11, 32'h12348765, 0, 0,
                  0, 0, 32'h100, 4'b0011, 32'h0, 1, 32'hFFFF8765, 3);
`endif

    // Reset state
    #1;
    chk("rst/busy", {31'd0, busy}, 32'd0);
    chk("rst/done", {31'd0, done}, 32'd0);
    chk("rst/mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst/mem_addr", mem_addr, 32'd0);
    chk("rst/mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst/rf_en", {31'd0, rf_en}, 32'd0);
    chk("rst/rf_data", rf_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Table, applied back to back
    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Reset while REQ waits for a grant: mem_req must drop without a clock.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b010; base = 32'h100; rd_in = 5'd5;
    @(negedge clk);
    idle_inputs();
    chk("rstreq/mem_req_before", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstreq/mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstreq/busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in WAIT: no write-back even if rvalid shows up afterwards.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b010; base = 32'h100; rd_in = 5'd5;
    @(negedge clk);
    start = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstwait/busy", {31'd0, busy}, 32'd0);
    chk("rstwait/mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstwait/rf_en", {31'd0, rf_en}, 32'd0);
    last_rd = 5'd0;
    last_data = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstwait/no_done", {31'd0, done}, 32'd0);
      chk("rstwait/no_rf_en", {31'd0, rf_en}, 32'd0);
    end
    idle_inputs();

    // IDLE accepts a new start after reset
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
`default_nettype wire
